alu_acc_sequencer: RTL and testbench

//  Multi-cycle control stage directly upstream of the 4-bit alu.
//  - Accepts one command per handshake.
//  - Drives the alu operand and select inputs, and captures alu y into a 4-bit accumulator.
//  - Repeats the operation N times: multi-bit shifts and repeated add (small multiply).
//  - Returns the final accumulator over a response handshake.

---
 rtl/alu_acc_sequencer_pkg.sv | 26 ++
 rtl/alu_acc_sequencer_if.sv | 46 ++++
 rtl/alu_acc_sequencer.sv | 121 ++++++++++++
 tb/tb_alu_acc_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_acc_sequencer_pkg.sv
// Shared types and constants for the alu accumulator sequencer.
package alu_acc_sequencer_pkg;

    // Datapath width matches the 4-bit alu and is not meant to change.
    localparam int WIDTH = 4;
    // Repeat-count width; a command makes up to 2**CNT_W alu passes.
    localparam int CNT_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Frequently used alu select codes, written as {s3,s2,s1,s0}.
    localparam logic [3:0] SEL_ADD = 4'b0000;
    localparam logic [3:0] SEL_SUB = 4'b0001;
    localparam logic [3:0] SEL_SHR = 4'b0100;
    localparam logic [3:0] SEL_SHL = 4'b1100;

    // True when a datapath word is all zeros.
    function automatic logic is_zero(input logic [WIDTH-1:0] v);
        return (v == {WIDTH{1'b0}});
    endfunction

endpackage

// File: rtl/alu_acc_sequencer_if.sv
// Command, alu-drive and response signals of the sequencer, bundled.
// master = command source / response sink / alu; slave = the sequencer.
interface alu_acc_sequencer_if;
    import alu_acc_sequencer_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_load;
    logic [3:0]       cmd_sel;
    logic             cmd_cin;
    logic [WIDTH-1:0] cmd_b;
    logic [CNT_W-1:0] cmd_reps;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_s0;
    logic             alu_s1;
    logic             alu_s2;
    logic             alu_s3;
    logic             alu_cin;
    logic [WIDTH-1:0] alu_y;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_acc;
    logic             rsp_zero;

    modport master (
        output cmd_valid, cmd_load, cmd_sel, cmd_cin, cmd_b, cmd_reps,
        input  cmd_ready,
        input  alu_a, alu_b, alu_s0, alu_s1, alu_s2, alu_s3, alu_cin,
        output alu_y,
        input  rsp_valid, rsp_acc, rsp_zero,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_load, cmd_sel, cmd_cin, cmd_b, cmd_reps,
        output cmd_ready,
        output alu_a, alu_b, alu_s0, alu_s1, alu_s2, alu_s3, alu_cin,
        input  alu_y,
        output rsp_valid, rsp_acc, rsp_zero,
        input  rsp_ready
    );

endinterface

// File: rtl/alu_acc_sequencer.sv
// Multi-cycle control stage in front of the 4-bit alu: takes one command,
// runs the alu reps+1 times on the accumulator, and returns the result.
module alu_acc_sequencer
    import alu_acc_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    alu_acc_sequencer_if.slave  seq_if
);

    state_e           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [CNT_W-1:0] cnt_q;
    // Latched command fields; they double as the alu drive and are
    // therefore non-zero only while EXEC is running.
    logic [WIDTH-1:0] alu_b_q;
    logic [3:0]       alu_sel_q;
    logic             alu_cin_q;
    logic             cmd_ready_q;
    logic             rsp_valid_q;
    logic             rsp_zero_q;
    logic             accept_s;

    assign accept_s = seq_if.cmd_valid & cmd_ready_q;

    // Next accumulator value: load at accept, alu result while executing.
    always_comb begin
        acc_d = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && seq_if.cmd_load) begin
                    acc_d = seq_if.cmd_b;
                end else begin
                    acc_d = acc_q;
                end
            end
            ST_EXEC: acc_d = seq_if.alu_y;
            ST_RESP: acc_d = acc_q;
            default: acc_d = acc_q;
        endcase
    end

    // Control FSM with pass counter, latched fields and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= {WIDTH{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            alu_b_q     <= {WIDTH{1'b0}};
            alu_sel_q   <= 4'b0000;
            alu_cin_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_zero_q  <= 1'b1;
        end else begin
            acc_q      <= acc_d;
            rsp_zero_q <= is_zero(acc_d);
            case (state_q)
                ST_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (accept_s) begin
                        cmd_ready_q <= 1'b0;
                        cnt_q       <= seq_if.cmd_reps;
                        if (seq_if.cmd_load) begin
                            // Loads make no alu pass, so the alu drive stays zero.
                            rsp_valid_q <= 1'b1;
                            state_q     <= ST_RESP;
                        end else begin
                            alu_b_q   <= seq_if.cmd_b;
                            alu_sel_q <= seq_if.cmd_sel;
                            alu_cin_q <= seq_if.cmd_cin;
                            state_q   <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        alu_b_q     <= {WIDTH{1'b0}};
                        alu_sel_q   <= 4'b0000;
                        alu_cin_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_RESP: begin
                    if (seq_if.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        rsp_valid_q <= 1'b1;
                    end
                end
                default: begin
                    alu_b_q     <= {WIDTH{1'b0}};
                    alu_sel_q   <= 4'b0000;
                    alu_cin_q   <= 1'b0;
                    cmd_ready_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign seq_if.cmd_ready = cmd_ready_q;
    assign seq_if.alu_a     = acc_q;
    assign seq_if.alu_b     = alu_b_q;
    assign seq_if.alu_s0    = alu_sel_q[0];
    assign seq_if.alu_s1    = alu_sel_q[1];
    assign seq_if.alu_s2    = alu_sel_q[2];
    assign seq_if.alu_s3    = alu_sel_q[3];
    assign seq_if.alu_cin   = alu_cin_q;
    assign seq_if.rsp_valid = rsp_valid_q;
    assign seq_if.rsp_acc   = acc_q;
    assign seq_if.rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// Bench for alu_acc_sequencer: a behavioural 4-bit alu closes the loop,
// directed scenarios plus random commands are checked against a model.
module tb_alu_acc_sequencer;
    import alu_acc_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   model_acc = 0;

    always #5 clk = ~clk;

    alu_acc_sequencer_if bus ();

    alu_acc_sequencer dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .seq_if (bus)
    );

    // Behavioural alu; logic group is and/or/xor/not-a.
    always_comb begin
        bus.alu_y = 4'b0000;
        case ({bus.alu_s3, bus.alu_s2})
            2'b00: begin
                case ({bus.alu_s1, bus.alu_s0})
                    2'b00:   bus.alu_y = bus.alu_a + bus.alu_b + {3'b000, bus.alu_cin};
                    2'b01:   bus.alu_y = bus.alu_a + ~bus.alu_b + {3'b000, bus.alu_cin};
                    2'b10:   bus.alu_y = bus.alu_a + {3'b000, bus.alu_cin};
                    default: bus.alu_y = bus.alu_a + 4'b1111 + {3'b000, bus.alu_cin};
                endcase
            end
            2'b10: begin
                case ({bus.alu_s1, bus.alu_s0})
                    2'b00:   bus.alu_y = bus.alu_a & bus.alu_b;
                    2'b01:   bus.alu_y = bus.alu_a | bus.alu_b;
                    2'b10:   bus.alu_y = bus.alu_a ^ bus.alu_b;
                    default: bus.alu_y = ~bus.alu_a;
                endcase
            end
            2'b01:   bus.alu_y = bus.alu_a >> 1;
            default: bus.alu_y = bus.alu_a << 1;
        endcase
    end

    // One alu pass in plain integer arithmetic, modulo 16.
    function automatic int ref_pass(input int a, input int sel, input int cin, input int b);
        int r;
        case (sel / 4)
            0: begin
                case (sel % 4)
                    0:       r = a + b + cin;
                    1:       r = a + (15 - b) + cin;
                    2:       r = a + cin;
                    default: r = a + 15 + cin;
                endcase
            end
            2: begin
                case (sel % 4)
                    0:       r = a & b;
                    1:       r = a | b;
                    2:       r = a ^ b;
                    default: r = 15 - a;
                endcase
            end
            1:       r = a / 2;
            default: r = a * 2;
        endcase
        return r % 16;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one command, check latency/result, apply `hold` cycles of backpressure.
    task automatic run_cmd(input logic load, input logic [3:0] sel, input logic cin,
                           input logic [3:0] b, input logic [1:0] reps,
                           input int hold, input string tag);
        int n;
        int lat;
        int exp_lat;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_load  = load;
        bus.cmd_sel   = sel;
        bus.cmd_cin   = cin;
        bus.cmd_b     = b;
        bus.cmd_reps  = reps;
        if (load) begin
            model_acc = int'(b);
            exp_lat   = 1;
        end else begin
            for (int i = 0; i <= int'(reps); i++) begin
                model_acc = ref_pass(model_acc, int'(sel), int'(cin), int'(b));
            end
            exp_lat = int'(reps) + 2;
        end
        @(posedge clk); #1;
        // Fields changing after accept must have no effect.
        bus.cmd_valid = 1'b0;
        bus.cmd_load  = 1'($urandom);
        bus.cmd_sel   = 4'($urandom);
        bus.cmd_cin   = 1'($urandom);
        bus.cmd_b     = 4'($urandom);
        bus.cmd_reps  = 2'($urandom);
        if (!load) begin
            check({tag, "_alu_b"}, 32'(bus.alu_b), 32'(b));
            check({tag, "_alu_sel"}, 32'({bus.alu_s3, bus.alu_s2, bus.alu_s1, bus.alu_s0}), 32'(sel));
            check({tag, "_alu_cin"}, 32'(bus.alu_cin), 32'(cin));
        end
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_acc"}, 32'(bus.rsp_acc), 32'(model_acc));
        check({tag, "_zero"}, 32'(bus.rsp_zero), 32'(model_acc == 0));
        check({tag, "_busy"}, 32'(bus.cmd_ready), 32'd0);
        check({tag, "_alu_b_idle"}, 32'(bus.alu_b), 32'd0);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
            check({tag, "_hold_acc"}, 32'(bus.rsp_acc), 32'(model_acc));
            check({tag, "_hold_busy"}, 32'(bus.cmd_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check({tag, "_rsp_done"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_back_idle"}, 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_load  = 1'b0;
        bus.cmd_sel   = 4'b0000;
        bus.cmd_cin   = 1'b0;
        bus.cmd_b     = 4'b0000;
        bus.cmd_reps  = 2'b00;
        bus.rsp_ready = 1'b0;

        // Reset state
        #12;
        check("rst_ready", 32'(bus.cmd_ready), 32'd0);
        check("rst_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_acc", 32'(bus.rsp_acc), 32'd0);
        check("rst_alu_b", 32'(bus.alu_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_ready", 32'(bus.cmd_ready), 32'd1);
        model_acc = 0;

        // T1 load then add
        run_cmd(1'b1, SEL_ADD, 1'b0, 4'b0011, 2'd0, 0, "t1_load");
        run_cmd(1'b0, SEL_ADD, 1'b0, 4'b0010, 2'd0, 0, "t1_add");
        // T2 repeated add
        run_cmd(1'b1, SEL_ADD, 1'b0, 4'b0011, 2'd0, 0, "t2_load");
        run_cmd(1'b0, SEL_ADD, 1'b0, 4'b0010, 2'd2, 0, "t2_add3");
        // T3 shifts
        run_cmd(1'b1, SEL_ADD, 1'b0, 4'b0011, 2'd0, 0, "t3_load");
        run_cmd(1'b0, SEL_SHL, 1'b0, 4'b0000, 2'd1, 0, "t3_shl");
        run_cmd(1'b0, SEL_SHR, 1'b0, 4'b0000, 2'd3, 0, "t3_shr");
        // T4 subtract and wrap
        run_cmd(1'b1, SEL_ADD, 1'b0, 4'b0111, 2'd0, 0, "t4_load7");
        run_cmd(1'b0, SEL_SUB, 1'b1, 4'b0010, 2'd0, 0, "t4_sub");
        run_cmd(1'b1, SEL_ADD, 1'b0, 4'b1111, 2'd0, 0, "t4_load15");
        run_cmd(1'b0, SEL_ADD, 1'b0, 4'b0001, 2'd0, 0, "t4_wrap");
        // T5 backpressure
        run_cmd(1'b0, SEL_ADD, 1'b1, 4'b0100, 2'd1, 5, "t5_bp");

        // T6 reset mid-EXEC
        bus.cmd_valid = 1'b1;
        bus.cmd_load  = 1'b0;
        bus.cmd_sel   = SEL_ADD;
        bus.cmd_cin   = 1'b0;
        bus.cmd_b     = 4'b0001;
        bus.cmd_reps  = 2'd3;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid", 32'(bus.rsp_valid), 32'd0);
        check("t6_acc", 32'(bus.rsp_acc), 32'd0);
        check("t6_ready", 32'(bus.cmd_ready), 32'd0);
        check("t6_alu_b", 32'(bus.alu_b), 32'd0);
        model_acc = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("t6_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        run_cmd(1'b0, SEL_ADD, 1'b0, 4'b0011, 2'd0, 0, "t6_after");

        // Random commands
        for (int r = 0; r < 40; r++) begin
            run_cmd(($urandom_range(0, 4) == 0), 4'($urandom), 1'($urandom),
                    4'($urandom), 2'($urandom), int'($urandom_range(0, 3)), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
